// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result write-back stage: captures result words, writes them over the shared bus, updates Z/N/C flags
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_oe,
  input  logic              res_valid,
  input  logic [2:0]        wr_mask,
  input  logic              carry_upd,
  input  logic [DATA_W-1:0] dst,
  input  logic [DATA_W-1:0] dst_h,
  input  logic [DATA_W-1:0] src0,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] dsth_addr,
  input  logic [ADDR_W-1:0] src0_addr,
  input  logic              is_bus_busy,
  input  logic              bus_ack,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              done,
  output logic [2:0]        flags,
  output logic              overrun
);

  typedef enum logic [2:0] {IDLE, WR_DST, WR_DSTH, WR_SRC0, DONE} state_t;

  state_t            state_q;
  logic [2:1]        mask_q;
  logic [DATA_W-1:0] dst_q, dsth_q, src0_q;
  logic [ADDR_W-1:0] dst_addr_q, dsth_addr_q, src0_addr_q;
  logic              bus_req_q, done_q, overrun_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_data_q;
  logic [2:0]        flags_q;

  state_t            next_wr_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  // Lowest remaining mask bit wins: dst, then dst_h, then src0.
  function automatic state_t first_from(input logic [2:0] m);
    if (m[0])      return WR_DST;
    else if (m[1]) return WR_DSTH;
    else if (m[2]) return WR_SRC0;
    else           return DONE;
  endfunction

  always_comb begin
    next_wr_d = DONE;
    wr_addr_d = dst_addr_q;
    wr_data_d = dst_q;
    case (state_q)
      WR_DST: next_wr_d = first_from({mask_q[2:1], 1'b0});
      WR_DSTH: begin
        next_wr_d = first_from({mask_q[2], 2'b00});
        wr_addr_d = dsth_addr_q;
        wr_data_d = dsth_q;
      end
      WR_SRC0: begin
        wr_addr_d = src0_addr_q;
        wr_data_d = src0_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      dst_q       <= '0;
      dsth_q      <= '0;
      src0_q      <= '0;
      dst_addr_q  <= '0;
      dsth_addr_q <= '0;
      src0_addr_q <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      done_q      <= 1'b0;
      flags_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      // done is only ever set for one edge, so it drops on the next clk edge even when disabled.
      done_q <= 1'b0;
      if (clk_oe) begin
        if (res_valid && state_q != IDLE) overrun_q <= 1'b1;
        case (state_q)
          IDLE: begin
            if (res_valid) begin
              mask_q      <= wr_mask[2:1];
              dst_q       <= dst;
              dsth_q      <= dst_h;
              src0_q      <= src0;
              dst_addr_q  <= dst_addr;
              dsth_addr_q <= dsth_addr;
              src0_addr_q <= src0_addr;
              flags_q     <= {carry_upd ? dst_h[0] : flags_q[2], dst[DATA_W-1], dst == '0};
              state_q     <= first_from(wr_mask);
            end
          end
          WR_DST, WR_DSTH, WR_SRC0: begin
            if (!bus_req_q) begin
              if (!is_bus_busy) begin
                bus_req_q  <= 1'b1;
                bus_addr_q <= wr_addr_d;
                bus_data_q <= wr_data_d;
              end
            end else if (bus_ack) begin
              bus_req_q <= 1'b0;
              state_q   <= next_wr_d;
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus_req  = bus_req_q;
  assign bus_addr = bus_addr_q;
  assign bus_data = bus_data_q;
  assign done     = done_q;
  assign flags    = flags_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - randomized self-checking bench for alu_writeback against a write-list/flag model
module tb_alu_writeback;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clk_oe, res_valid, carry_upd, is_bus_busy, bus_ack;
  logic [2:0]    wr_mask;
  logic [DW-1:0] dst, dst_h, src0;
  logic [AW-1:0] dst_addr, dsth_addr, src0_addr;
  logic          bus_req, done, overrun;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  logic [2:0]    flags;

  alu_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .res_valid(res_valid), .wr_mask(wr_mask),
    .carry_upd(carry_upd), .dst(dst), .dst_h(dst_h), .src0(src0), .dst_addr(dst_addr),
    .dsth_addr(dsth_addr), .src0_addr(src0_addr), .is_bus_busy(is_bus_busy), .bus_ack(bus_ack),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_data(bus_data), .done(done), .flags(flags),
    .overrun(overrun)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic model_c = 1'b0;
  logic exp_ovr = 1'b0;
  logic [2:0] exp_flags;
  logic [AW-1:0] exp_a[$];
  logic [DW-1:0] exp_d[$];

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_alu();
    dst = $urandom; dst_h = $urandom; src0 = $urandom;
    dst_addr = $urandom; dsth_addr = $urandom; src0_addr = $urandom;
    wr_mask = 3'($urandom); carry_upd = 1'($urandom);
  endtask

  // Expected writes are the set mask bits in dst, dst_h, src0 order.
  task automatic build_expect();
    exp_a.delete(); exp_d.delete();
    if (wr_mask[0]) begin exp_a.push_back(dst_addr);  exp_d.push_back(dst);   end
    if (wr_mask[1]) begin exp_a.push_back(dsth_addr); exp_d.push_back(dst_h); end
    if (wr_mask[2]) begin exp_a.push_back(src0_addr); exp_d.push_back(src0);  end
    if (carry_upd) model_c = dst_h[0];
    exp_flags = {model_c, dst[DW-1], (dst == 0)};
  endtask

  task automatic capture();
    res_valid = 1'b1; clk_oe = 1'b1;
    cyc();
    res_valid = 1'b0;
    scramble_alu();
  endtask

  task automatic run_random(input bit rnd_oe, input bit rnd_busy, input bit poke);
    logic req0, oe, bz, ak, seen_done;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    int poke_at;
    scramble_alu();
    if ($urandom % 4 == 0) dst = '0;
    build_expect();
    is_bus_busy = 1'b0; bus_ack = 1'b0;
    capture();
    expect_eq("cap_flags", flags, exp_flags);
    poke_at = poke ? int'($urandom_range(0, 3)) : -1;
    seen_done = 1'b0;
    for (int i = 0; i < 400 && !seen_done; i++) begin
      oe = rnd_oe ? 1'($urandom) : 1'b1;
      bz = rnd_busy ? ($urandom % 3 == 0) : 1'b0;
      ak = bus_req ? 1'($urandom) : ($urandom % 4 == 0);
      clk_oe = oe; is_bus_busy = bz; bus_ack = ak;
      if (i == poke_at) begin
        res_valid = 1'b1;
        scramble_alu();
        if (oe) exp_ovr = 1'b1;
      end
      req0 = bus_req; a0 = bus_addr; d0 = bus_data;
      cyc();
      res_valid = 1'b0;
      if (req0 && ak && oe) begin
        if (exp_a.size() == 0) expect_eq("extra_write", 1, 0);
        else begin
          expect_eq("wr_addr", a0, exp_a.pop_front());
          expect_eq("wr_data", d0, exp_d.pop_front());
        end
        expect_eq("req_drop", bus_req, 0);
      end else if (req0) begin
        expect_eq("req_hold", bus_req, 1);
        expect_eq("addr_hold", bus_addr, a0);
        expect_eq("data_hold", bus_data, d0);
      end else if (bz || !oe) begin
        expect_eq("req_blocked", bus_req, 0);
      end
      if (done) begin
        seen_done = 1'b1;
        expect_eq("done_early", exp_a.size(), 0);
      end
    end
    if (!seen_done) expect_eq("done_timeout", 0, 1);
    clk_oe = 1'($urandom); bus_ack = 1'b1; is_bus_busy = 1'b0;
    cyc();
    expect_eq("done_width", done, 0);
    expect_eq("no_restart", bus_req, 0);
    expect_eq("flags_end", flags, exp_flags);
    expect_eq("overrun", overrun, exp_ovr);
  endtask

  initial begin
    rst = 1'b1; clk_oe = 1'b0; res_valid = 1'b0; is_bus_busy = 1'b0; bus_ack = 1'b0;
    scramble_alu();
    cyc(); cyc();
    rst = 1'b0;
    expect_eq("rst_req", bus_req, 0);
    expect_eq("rst_addr", bus_addr, 0);
    expect_eq("rst_data", bus_data, 0);
    expect_eq("rst_done", done, 0);
    expect_eq("rst_flags", flags, 0);
    expect_eq("rst_ovr", overrun, 0);

    // ADD: one write of dst=0, carry from dst_h[0]=1.
    wr_mask = 3'b001; carry_upd = 1'b1; dst = '0; dst_h = 32'd1; dst_addr = 32'h0000_1000;
    build_expect();
    bus_ack = 1'b1;
    capture();
    expect_eq("add_flags", flags, 3'b101);
    expect_eq("add_req_e0", bus_req, 0);
    cyc();
    expect_eq("add_req_e1", bus_req, 1);
    expect_eq("add_addr_e1", bus_addr, 32'h0000_1000);
    expect_eq("add_data_e1", bus_data, 0);
    cyc();
    expect_eq("add_req_e2", bus_req, 0);
    expect_eq("add_done_e2", done, 0);
    cyc();
    expect_eq("add_done_e3", done, 1);
    cyc();
    expect_eq("add_done_e4", done, 0);

    // Mask 000: done after one enabled edge, no bus activity.
    wr_mask = 3'b000; carry_upd = 1'b0;
    build_expect();
    capture();
    expect_eq("m0_req_e0", bus_req, 0);
    expect_eq("m0_done_e0", done, 0);
    cyc();
    expect_eq("m0_done_e1", done, 1);
    expect_eq("m0_req_e1", bus_req, 0);
    cyc();
    expect_eq("m0_done_e2", done, 0);

    for (int t = 0; t < 20; t++) run_random(1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 25; t++) run_random(1'b1, 1'b1, 1'b0);
    for (int t = 0; t < 10; t++) run_random(1'b1, 1'b1, 1'b1);

    // Reset while a request awaits ack.
    wr_mask = 3'b011;
    build_expect();
    bus_ack = 1'b0; is_bus_busy = 1'b0;
    capture();
    cyc();
    expect_eq("mid_req", bus_req, 1);
    rst = 1'b1; clk_oe = 1'b0; bus_ack = 1'b1;
    cyc();
    rst = 1'b0;
    model_c = 1'b0; exp_ovr = 1'b0;
    expect_eq("mid_rst_req", bus_req, 0);
    expect_eq("mid_rst_flags", flags, 0);
    expect_eq("mid_rst_done", done, 0);
    expect_eq("mid_rst_ovr", overrun, 0);
    clk_oe = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_eq("post_rst_req", bus_req, 0);
      expect_eq("post_rst_done", done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
